// File: rtl/hv_unbind_search_if.sv
// Query, item-stream and result handshakes of the hypervector unbind/search block.
// The master side supplies queries and items, the slave side is the search engine.
interface hv_unbind_search_if #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumItems    = 32
);
  localparam int unsigned CountWidth = $clog2(NumItems + 1);
  localparam int unsigned IdxWidth   = $clog2(NumItems);
  localparam int unsigned DistWidth  = $clog2(HVDimension + 1);

  logic [HVDimension-1:0] query_i;
  logic [HVDimension-1:0] key_i;
  logic [1:0]             unbind_op_i;
  logic [1:0]             shift_amt_i;
  logic [CountWidth-1:0]  num_items_i;
  logic                   query_valid_i;
  logic                   query_ready_o;

  logic [HVDimension-1:0] item_i;
  logic                   item_valid_i;
  logic                   item_ready_o;

  logic [IdxWidth-1:0]    res_idx_o;
  logic [DistWidth-1:0]   res_dist_o;
  logic                   res_valid_o;
  logic                   res_ready_i;

  modport master (
    output query_i, key_i, unbind_op_i, shift_amt_i, num_items_i, query_valid_i,
    input  query_ready_o,
    output item_i, item_valid_i,
    input  item_ready_o,
    input  res_idx_o, res_dist_o, res_valid_o,
    output res_ready_i
  );

  modport slave (
    input  query_i, key_i, unbind_op_i, shift_amt_i, num_items_i, query_valid_i,
    output query_ready_o,
    input  item_i, item_valid_i,
    output item_ready_o,
    output res_idx_o, res_dist_o, res_valid_o,
    input  res_ready_i
  );
endinterface

// File: rtl/hv_unbind_search.sv
// Unbinds an encoded query (XOR key and/or inverse rotation), then scans a stream of
// item hypervectors and reports the index and Hamming distance of the closest one.
module hv_unbind_search #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumItems    = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  hv_unbind_search_if.slave bus
);
  localparam int unsigned CountWidth = $clog2(NumItems + 1);
  localparam int unsigned IdxWidth   = $clog2(NumItems);
  localparam int unsigned DistWidth  = $clog2(HVDimension + 1);
  localparam int unsigned W          = HVDimension;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          unbound_q, unbound_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [DistWidth-1:0]  best_dist_q, best_dist_d;
  logic [IdxWidth-1:0]   best_idx_q, best_idx_d;
  logic                  query_ready_q, query_ready_d;
  logic                  item_ready_q, item_ready_d;
  logic                  res_valid_q, res_valid_d;

  logic [W-1:0]          bound_c;
  logic [W-1:0]          rot_src_c;
  logic [W-1:0]          unbind_c;
  logic [CountWidth-1:0] count_c;
  logic [W-1:0]          diff_c;
  logic [DistWidth-1:0]  dist_c;

  // Ops 0 and 3 use query^key, ops 1 and 2 the raw query; ops 2 and 3 also rotate left.
  always_comb begin
    bound_c   = bus.query_i ^ bus.key_i;
    rot_src_c = (bus.unbind_op_i[1] == bus.unbind_op_i[0]) ? bound_c : bus.query_i;
    unbind_c  = rot_src_c;
    if (bus.unbind_op_i[1]) begin
      unique case (bus.shift_amt_i)
        2'd0:    unbind_c = {rot_src_c[W-2:0],  rot_src_c[W-1]};
        2'd1:    unbind_c = {rot_src_c[W-5:0],  rot_src_c[W-1:W-4]};
        2'd2:    unbind_c = {rot_src_c[W-9:0],  rot_src_c[W-1:W-8]};
        default: unbind_c = {rot_src_c[W-17:0], rot_src_c[W-1:W-16]};
      endcase
    end
  end

  always_comb begin
    count_c = bus.num_items_i;
    if (bus.num_items_i > CountWidth'(NumItems)) count_c = CountWidth'(NumItems);
  end

  // Hamming distance between the unbound query and the current item beat.
  always_comb begin
    diff_c = unbound_q ^ bus.item_i;
    dist_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      dist_c = dist_c + DistWidth'(diff_c[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    unbound_d   = unbound_q;
    count_d     = count_q;
    cnt_d       = cnt_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;

    unique case (state_q)
      IDLE: begin
        if (query_ready_q && bus.query_valid_i) begin
          unbound_d   = unbind_c;
          count_d     = count_c;
          cnt_d       = '0;
          best_dist_d = '1;
          best_idx_d  = '0;
          state_d     = (count_c == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (item_ready_q && bus.item_valid_i) begin
          // Strict compare keeps the earliest index on ties.
          if (dist_c < best_dist_q) begin
            best_dist_d = dist_c;
            best_idx_d  = IdxWidth'(cnt_q);
          end
          cnt_d = cnt_q + CountWidth'(1);
          if (cnt_q == count_q - CountWidth'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (res_valid_q && bus.res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    query_ready_d = (state_d == IDLE);
    item_ready_d  = (state_d == SCAN);
    res_valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      unbound_q     <= '0;
      count_q       <= '0;
      cnt_q         <= '0;
      best_dist_q   <= '0;
      best_idx_q    <= '0;
      query_ready_q <= 1'b0;
      item_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      unbound_q     <= unbound_d;
      count_q       <= count_d;
      cnt_q         <= cnt_d;
      best_dist_q   <= best_dist_d;
      best_idx_q    <= best_idx_d;
      query_ready_q <= query_ready_d;
      item_ready_q  <= item_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign bus.query_ready_o = query_ready_q;
  assign bus.item_ready_o  = item_ready_q;
  assign bus.res_valid_o   = res_valid_q;
  assign bus.res_idx_o     = best_idx_q;
  assign bus.res_dist_o    = best_dist_q;
endmodule

// File: tb/tb_hv_unbind_search.sv
// Directed bench for hv_unbind_search: a vector table plus hand sequences for
// clamping and mid-scan reset.
module tb_hv_unbind_search;
  localparam int unsigned D = 512;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  hv_unbind_search_if #(.HVDimension(D), .NumItems(32)) bus ();
  hv_unbind_search #(.HVDimension(D), .NumItems(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [D-1:0] query;
    logic [D-1:0] key;
    logic [1:0]   op;
    logic [1:0]   sh;
    logic [5:0]   num;
    bit           gap;
    bit           hold;
    int           exp_idx;
    int           exp_dist;
    logic [D-1:0] items[8];
  } vec_t;

  vec_t         vecs[11];
  logic [D-1:0] cur_items[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Non-periodic pseudo-random pattern so rotations by any amount are visible.
  function automatic logic [D-1:0] mix(input int s);
    logic [D-1:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = 32'h9E37_79B9 * 32'(s * 16 + j + 1);
    return r;
  endfunction

  // Models the encoder's right rotation.
  function automatic logic [D-1:0] rotr(input logic [D-1:0] a, input int k);
    return (a >> k) | (a << (D - k));
  endfunction

  function automatic logic [D-1:0] ones(input int m);
    return (D'(1) << m) - D'(1);
  endfunction

  function automatic vec_t mk(input logic [D-1:0] q, input logic [D-1:0] k, input logic [1:0] op,
                              input logic [1:0] sh, input logic [5:0] n, input bit gap,
                              input bit hold, input int ei, input int ed);
    vec_t v;
    v.query = q; v.key = k; v.op = op; v.sh = sh; v.num = n;
    v.gap = gap; v.hold = hold; v.exp_idx = ei; v.exp_dist = ed;
    for (int i = 0; i < 8; i++) v.items[i] = mix(100 + i);
    return v;
  endfunction

  task automatic run_query(input int id, input logic [D-1:0] q, input logic [D-1:0] k,
                           input logic [1:0] op, input logic [1:0] sh, input logic [5:0] n,
                           input bit gap, input bit hold, input int ei, input int ed);
    int n_eff, lat, acc, wait_n, exp_lat;
    bit qr_bad;
    n_eff   = (n > 6'd32) ? 32 : int'(n);
    exp_lat = (n_eff == 0) ? 0 : (gap ? 2 * n_eff - 1 : n_eff);
    @(negedge clk_i);
    bus.query_i = q; bus.key_i = k; bus.unbind_op_i = op; bus.shift_amt_i = sh;
    bus.num_items_i = n; bus.query_valid_i = 1'b1;
    wait_n = 0;
    while (!bus.query_ready_o && wait_n < 20) begin
      @(negedge clk_i);
      wait_n++;
    end
    chk($sformatf("v%0d_qready", id), 32'(bus.query_ready_o), 32'd1);
    @(negedge clk_i);
    // Controls change after acceptance and query_valid stays high; both must be ignored.
    bus.query_i = ~q; bus.key_i = ~k; bus.unbind_op_i = ~op; bus.shift_amt_i = ~sh;
    bus.num_items_i = 6'd1;
    lat = 0; acc = 0; qr_bad = 1'b0;
    while (!bus.res_valid_o && lat < 200) begin
      if (bus.query_ready_o) qr_bad = 1'b1;
      if (!gap || (lat % 2 == 0)) begin
        bus.item_i = cur_items[acc & 63];
        bus.item_valid_i = 1'b1;
        if (bus.item_ready_o) acc++;
      end else begin
        bus.item_i = '1;
        bus.item_valid_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    bus.item_valid_i = 1'b0;
    chk($sformatf("v%0d_res_valid", id), 32'(bus.res_valid_o), 32'd1);
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(exp_lat));
    chk($sformatf("v%0d_accepted", id), 32'(acc), 32'(n_eff));
    chk($sformatf("v%0d_idx", id), 32'(bus.res_idx_o), 32'(ei));
    chk($sformatf("v%0d_dist", id), 32'(bus.res_dist_o), 32'(ed));
    chk($sformatf("v%0d_item_ready_done", id), 32'(bus.item_ready_o), 32'd0);
    chk($sformatf("v%0d_qready_busy", id), 32'(qr_bad), 32'd0);
    if (hold) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk_i);
        chk($sformatf("v%0d_hold%0d_valid", id, h), 32'(bus.res_valid_o), 32'd1);
        chk($sformatf("v%0d_hold%0d_idx", id, h), 32'(bus.res_idx_o), 32'(ei));
        chk($sformatf("v%0d_hold%0d_dist", id, h), 32'(bus.res_dist_o), 32'(ed));
        chk($sformatf("v%0d_hold%0d_qready", id, h), 32'(bus.query_ready_o), 32'd0);
      end
    end
    bus.query_valid_i = 1'b0;
    bus.res_ready_i = 1'b1;
    @(negedge clk_i);
    bus.res_ready_i = 1'b0;
    chk($sformatf("v%0d_valid_drop", id), 32'(bus.res_valid_o), 32'd0);
    chk($sformatf("v%0d_idle_after", id), 32'(bus.query_ready_o), 32'd1);
  endtask

  initial begin
    logic [D-1:0] k0, y, kk, q;

    k0 = mix(7); y = mix(30); kk = mix(31);
    vecs[0] = mk(k0 ^ mix(3), k0, 2'd0, 2'd0, 6'd4, 1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 4; i++) vecs[0].items[i] = mix(i + 1);
    vecs[1] = mk(rotr(mix(11), 16), '0, 2'd2, 2'd3, 6'd1, 1'b0, 1'b0, 0, 0);
    vecs[1].items[0] = mix(11);
    vecs[2] = mk(D'(1), '0, 2'd2, 2'd0, 6'd1, 1'b0, 1'b0, 0, 0);
    vecs[2].items[0] = D'(2);
    vecs[3] = mk(D'(1), '0, 2'd2, 2'd0, 6'd1, 1'b0, 1'b0, 0, 2);
    vecs[3].items[0] = D'(1);
    vecs[4] = mk('0, mix(9), 2'd1, 2'd0, 6'd4, 1'b0, 1'b0, 1, 5);
    vecs[4].items[0] = ones(9); vecs[4].items[1] = ones(5);
    vecs[4].items[2] = ones(7); vecs[4].items[3] = ones(5) << 100;
    vecs[5] = mk(mix(20), '0, 2'd1, 2'd0, 6'd3, 1'b0, 1'b0, 0, 512);
    for (int i = 0; i < 3; i++) vecs[5].items[i] = ~mix(20);
    vecs[6] = mk(rotr(y, 4) ^ kk, kk, 2'd3, 2'd1, 6'd2, 1'b0, 1'b0, 0, 0);
    vecs[6].items[0] = y; vecs[6].items[1] = y ^ D'(1);
    vecs[7] = mk(rotr(y, 8) ^ kk, kk, 2'd3, 2'd2, 6'd2, 1'b0, 1'b0, 1, 0);
    vecs[7].items[0] = y ^ D'(3); vecs[7].items[1] = y;
    vecs[8] = mk(mix(44), mix(45), 2'd0, 2'd0, 6'd0, 1'b0, 1'b0, 0, 1023);
    vecs[9] = mk(mix(40), '0, 2'd0, 2'd0, 6'd3, 1'b1, 1'b1, 1, 1);
    vecs[9].items[0] = mix(40) ^ D'(7); vecs[9].items[1] = mix(40) ^ D'(1);
    vecs[9].items[2] = mix(40) ^ D'(3);
    vecs[10] = mk(k0 ^ mix(50), k0, 2'd0, 2'd0, 6'd2, 1'b0, 1'b0, 0, 1);
    vecs[10].items[0] = mix(50) ^ (D'(1) << 511);
    vecs[10].items[1] = mix(50) ^ D'(3);

    rst_ni = 1'b0;
    bus.query_i = '0; bus.key_i = '0; bus.unbind_op_i = '0; bus.shift_amt_i = '0;
    bus.num_items_i = '0; bus.query_valid_i = 1'b0; bus.item_i = '0;
    bus.item_valid_i = 1'b0; bus.res_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_qready", 32'(bus.query_ready_o), 32'd0);
    chk("rst_item_ready", 32'(bus.item_ready_o), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst_idx", 32'(bus.res_idx_o), 32'd0);
    chk("rst_dist", 32'(bus.res_dist_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("release_qready", 32'(bus.query_ready_o), 32'd1);

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 64; i++) cur_items[i] = (i < 8) ? vecs[v].items[i] : mix(200 + i);
      run_query(v, vecs[v].query, vecs[v].key, vecs[v].op, vecs[v].sh, vecs[v].num,
                vecs[v].gap, vecs[v].hold, vecs[v].exp_idx, vecs[v].exp_dist);
    end

    // Count clamps at 32: item 31 is the closest accepted one, later items are closer still.
    q = mix(70);
    for (int i = 0; i < 64; i++) cur_items[i] = (i < 40) ? (q ^ ones(40 - i)) : q;
    run_query(20, q, mix(71), 2'd1, 2'd0, 6'd40, 1'b0, 1'b0, 31, 9);

    // Abort a scan after two items with reset.
    q = mix(80);
    for (int i = 0; i < 64; i++) cur_items[i] = (i == 5) ? q : (q ^ mix(90 + i));
    @(negedge clk_i);
    bus.query_i = q; bus.key_i = '0; bus.unbind_op_i = 2'd1; bus.shift_amt_i = '0;
    bus.num_items_i = 6'd8; bus.query_valid_i = 1'b1;
    @(negedge clk_i);
    bus.query_valid_i = 1'b0;
    bus.item_valid_i = 1'b1;
    bus.item_i = cur_items[0];
    @(negedge clk_i);
    bus.item_i = cur_items[1];
    @(negedge clk_i);
    chk("mid_scan_item_ready", 32'(bus.item_ready_o), 32'd1);
    bus.item_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("abort_qready", 32'(bus.query_ready_o), 32'd0);
    chk("abort_item_ready", 32'(bus.item_ready_o), 32'd0);
    chk("abort_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("abort_idx", 32'(bus.res_idx_o), 32'd0);
    chk("abort_dist", 32'(bus.res_dist_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_release_qready", 32'(bus.query_ready_o), 32'd1);
    chk("abort_release_valid", 32'(bus.res_valid_o), 32'd0);
    run_query(21, q, mix(81), 2'd1, 2'd2, 6'd8, 1'b0, 1'b0, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hv_unbind_search.md
# hv_unbind_search

Decoder-side counterpart to the encoder ALU processing element. It accepts one encoded query hypervector and recovers a candidate by unbinding it: XOR with a key and/or the inverse circular permutation. It then streams a set of item-memory hypervectors and reports the index and Hamming distance of the closest item. It sits between the encoder output and the item/associative memory. It is fully sequential: query handshake, item-stream handshake, result handshake.

## Interface
- HVDimension, 512, hypervector width in bits (≥ 32)
- NumItems, 32, maximum items scanned per query
- CountWidth, $clog2(NumItems+1), width of item count
- IdxWidth, $clog2(NumItems), width of result index
- DistWidth, $clog2(HVDimension+1), width of Hamming distance

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, synchronous and active-low
- query_i  in  HVDimension  encoded query
- key_i  in  HVDimension  binding key
- unbind_op_i  in  2  0: query XOR key; 1: query pass-through; 2: inverse rotate; 3: inverse rotate of (query XOR key)
- shift_amt_i  in  2  inverse rotate amount, rotate left by 0:1, 1:4, 2:8, 3:16 bits
- num_items_i  in  CountWidth  items to scan
- query_valid_i  in  1  query request
- query_ready_o  out  1  block can accept a query
- item_i  in  HVDimension  item hypervector, items arrive in index order 0,1,2…
- item_valid_i  in  1  item beat valid
- item_ready_o  out  1  item beat accepted
- res_idx_o  out  IdxWidth  index of closest item
- res_dist_o  out  DistWidth  Hamming distance of closest item
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed

## Operation
- Inverse rotate left by k: out = {A[HVDimension-1-k:0], A[HVDimension-1:HVDimension-k]}. This exactly undoes the encoder's right rotation by the same shift code.
- States: IDLE, SCAN, DONE.
- IDLE:
  - query_ready_o=1.
  - On query_valid_i: register the unbound HV, computed from query_i/key_i/unbind_op_i/shift_amt_i in the same cycle.
  - Register the count as min(num_items_i, NumItems).
  - Clear item counter; set best_dist to all-ones and best_idx to 0.
  - Go to SCAN, or to DONE if the count is 0.
- SCAN:
  - item_ready_o=1.
  - Each accepted beat computes dist = popcount(unbound ^ item_i), zero-extended to DistWidth.
  - If dist < best_dist (strict), update best_dist and best_idx to the counter value.
  - The counter increments on each accepted beat.
  - When the beat with counter = count-1 is accepted, go to DONE.
  - Cycles with item_valid_i low stall without effect.
- DONE:
  - res_valid_o=1, with res_idx_o/res_dist_o taken from the best registers.
  - On res_ready_i, go to IDLE.
- Ties: the earliest (lowest) index wins.
- Empty scan (count 0): result is dist = all-ones (e.g. 1023 for 512), idx = 0. This is distinguishable because it exceeds HVDimension.
- Outside their states:
  - query_valid_i is ignored outside IDLE.
  - item_valid_i is ignored outside SCAN (item_ready_o=0).
- Control inputs are sampled only at query acceptance. Later changes do not affect the running search.

## Timing
- Reset (rst_ni=0 at a clock edge):
  - state goes to IDLE; query_ready_o=0 while reset is asserted.
  - item_ready_o=0, res_valid_o=0, res_idx_o=0, res_dist_o=0; all internal registers cleared.
  - query_ready_o=1 in the first cycle after release.
- Reset mid-SCAN or mid-DONE aborts the search. No result is produced and partial state is discarded.
- Query accepted at edge T0:
  - item_ready_o=1 from cycle T0+1.
  - With item_valid_i held high, items are accepted at edges T0+1 … T0+N.
  - res_valid_o=1 in cycle T0+N+1.
  - Minimum latency is N+1 cycles. Throughput is one item per cycle.
- Empty scan: res_valid_o=1 in cycle T0+1.
- Result handshake:
  - res_idx_o/res_dist_o stay stable while res_valid_o=1 and res_ready_i=0.
  - On the handshake edge, the next cycle is IDLE with query_ready_o=1. Back-to-back queries therefore have one IDLE cycle between them.
  - res_valid_o drops the cycle after the handshake.
- No combinational path from any valid/ready input to any ready/valid output. All handshake outputs decode from registered state.

## Test plan
- XOR unbind, ideal stream:
  - query = key ^ item2, op 0, num_items 4, items 0..3 random and distinct.
  - Expect: res_idx 2, res_dist 0, res_valid_o exactly 5 cycles after query accept.
- Inverse permute:
  - query = X rotated right by 16, op 2, shift 3, item0 = X, num_items 1 → idx 0, dist 0.
  - Repeat with shift 0, query bit 0 only set, key 0, item0 = bit 1 only → dist 0.
  - Same query, item0 = bit 0 only → dist 2.
- Tie and strictness:
  - num_items 4, items at distances 9, 5, 7, 5 → idx 1, dist 5.
  - All items at distance 512 (inverted) → idx 0, dist 512.
- Backpressure:
  - item_valid_i low every other cycle, num_items 3.
  - res_ready_i low for 3 cycles after res_valid_o rises.
  - Expect: result stable, query_ready_o=0 throughout, IDLE one cycle after handshake.
- Boundaries:
  - num_items 0 → res_valid_o at T0+1, dist 1023, idx 0.
  - num_items 40 → exactly 32 items accepted, item_ready_o=0 afterwards.
- Reset mid-scan:
  - Assert rst_ni=0 after 2 of 8 items; all outputs go to 0.
  - After release, a new query with op 1 and item5 = query returns idx 5, dist 0.
